// File: rtl/coordinate_bcd_converter.sv
// Purpose: sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: done pulses BIN_W cycles after the start edge; one result per BIN_W+1 cycles.
// Backpressure: none; start is ignored while busy, and bcd holds until the next result.
module coordinate_bcd_converter #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESETN,
  input  logic                  start,
  input  logic [BIN_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [WORK_W-1:0]   work_q;    // BCD digits above the remaining binary bits
  logic [WORK_W-1:0]   work_adj;  // after the parallel add-3 correction
  logic [WORK_W-1:0]   work_d;    // corrected and shifted left by one
  logic [CNT_W-1:0]    cnt_q;     // shifts still to perform
  logic                busy_q;
  logic                done_q;
  logic [BCD_W-1:0]    bcd_q;

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

  // Add 3 to every BCD nibble >= 5 (judged on pre-shift contents), then shift the whole register left.
  always_comb begin
    work_adj = work_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[BIN_W + 4*d +: 4] >= 4'd5) begin
        work_adj[BIN_W + 4*d +: 4] = work_q[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    work_d = work_adj << 1;
  end

  // Control FSM with registered busy/done; bcd only updates on the edge that raises done.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      case (state_q)
        // DONE accepts a new start exactly like IDLE so back-to-back conversions lose no cycle.
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            work_q  <= {{BCD_W{1'b0}}, value};
            cnt_q   <= CNT_W'(BIN_W);
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          // Last shift: publish the digits taken from the freshly shifted register.
          if (cnt_q == CNT_W'(1)) begin
            bcd_q   <= work_d[WORK_W-1:BIN_W];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
